// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states and mode encodings.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// One-bit full adder; chained DIGIT times to form the per-cycle ripple datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: processes DIGIT bits per cycle, LSB digit first, over N = WIDTH/DIGIT cycles.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               mode_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   acc_next;

   logic [DIGIT-1:0]   a_dig;
   logic [DIGIT-1:0]   b_raw;
   logic [DIGIT-1:0]   b_dig;
   logic [DIGIT-1:0]   sum_dig;
   logic [DIGIT:0]     c;

   // Current digit of each operand; subtraction uses A + ~B + 1 with the +1 preloaded as carry.
   assign a_dig = a_q[cnt*DIGIT +: DIGIT];
   assign b_raw = b_q[cnt*DIGIT +: DIGIT];
   assign b_dig = (mode_q == MODE_ADD) ? b_raw : ~b_raw;
   assign c[0]  = carry;

   for (genvar k = 0; k < DIGIT; k++) begin : g_ripple
      fa_cell u_fa (
         .a     (a_dig[k]),
         .b     (b_dig[k]),
         .cin   (c[k]),
         .sum   (sum_dig[k]),
         .carry (c[k+1])
      );
   end

   always_comb begin
      acc_next = acc;
      acc_next[cnt*DIGIT +: DIGIT] = sum_dig;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         cnt    <= '0;
         carry  <= 1'b0;
         mode_q <= MODE_ADD;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  mode_q <= mode;
                  cnt    <= '0;
                  carry  <= mode;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= c[DIGIT];
               if (cnt == CNT_LAST) begin
                  // Signed overflow: carry into the MSB differs from carry out of it.
                  result <= acc_next;
                  cout   <= c[DIGIT];
                  ovf    <= c[DIGIT] ^ c[DIGIT-1];
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: one bit-serial (DIGIT=1) and one nibble-serial (DIGIT=4) instance.
module tb_serial_add_sub;

   typedef struct {
      logic [7:0] res;
      logic       co;
      logic       ov;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start1 = 1'b0, mode1 = 1'b0;
   logic [7:0] a1 = '0, b1 = '0;
   logic       busy1, done1, cout1, ovf1;
   logic [7:0] result1;
   logic       start4 = 1'b0, mode4 = 1'b0;
   logic [7:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] result4;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done1_cnt = 0;
   int done4_cnt = 0;
   exp_t sb1[$];
   exp_t sb4[$];

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
   );

   serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic m);
      logic [8:0] s;
      logic [7:0] bb;
      bb = m ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {8'd0, m};
      model.res = s[7:0];
      model.co  = s[8];
      model.ov  = (a[7] == bb[7]) && (s[7] != a[7]);
      model.cyc = 0;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         done1_cnt++;
         if (sb1.size() == 0) chk("d1_unexpected_done", done1, 1'b0);
         else begin
            e = sb1.pop_front();
            chk("d1_result", result1, e.res);
            chk("d1_cout", cout1, e.co);
            chk("d1_ovf", ovf1, e.ov);
            chk("d1_latency", cyc, e.cyc);
            chk("d1_busy_at_done", busy1, 1'b0);
         end
      end
      if (done4) begin
         done4_cnt++;
         if (sb4.size() == 0) chk("d4_unexpected_done", done4, 1'b0);
         else begin
            e = sb4.pop_front();
            chk("d4_result", result4, e.res);
            chk("d4_cout", cout4, e.co);
            chk("d4_ovf", ovf4, e.ov);
            chk("d4_latency", cyc, e.cyc);
            chk("d4_busy_at_done", busy4, 1'b0);
         end
      end
   end

   task automatic run_op(input int which, input logic [7:0] a, input logic [7:0] b, input logic m);
      exp_t e;
      @(negedge clk);
      e = model(a, b, m);
      if (which == 1) begin
         a1 = a; b1 = b; mode1 = m; start1 = 1'b1;
         e.cyc = cyc + 1 + 8;
         sb1.push_back(e);
      end else begin
         a4 = a; b4 = b; mode4 = m; start4 = 1'b1;
         e.cyc = cyc + 1 + 2;
         sb4.push_back(e);
      end
      @(posedge clk);
      #1;
      if (which == 1) chk("d1_busy", busy1, 1'b1);
      else            chk("d4_busy", busy4, 1'b1);
      // Scramble inputs after the start edge; the latched operands must be used.
      @(negedge clk);
      if (which == 1) begin
         start1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); mode1 = 1'($urandom);
         for (int i = 0; i < 40 && sb1.size() != 0; i++) @(posedge clk);
         if (sb1.size() != 0) begin
            chk("d1_timeout", sb1.size(), 0);
            sb1.delete();
         end
      end else begin
         start4 = 1'b0; a4 = 8'($urandom); b4 = 8'($urandom); mode4 = 1'($urandom);
         for (int i = 0; i < 40 && sb4.size() != 0; i++) @(posedge clk);
         if (sb4.size() != 0) begin
            chk("d4_timeout", sb4.size(), 0);
            sb4.delete();
         end
      end
   endtask

   initial begin
      int cnt_before;
      exp_t e;
      #12;
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_done1", done1, 1'b0);
      chk("rst_result1", result1, 8'h00);
      chk("rst_flags1", {cout1, ovf1}, 2'b00);
      chk("rst_busy4", busy4, 1'b0);
      chk("rst_result4", result4, 8'h00);
      @(posedge clk);
      #2 rst_n = 1'b1;

      run_op(1, 8'h7F, 8'h01, 1'b0);
      run_op(1, 8'hFF, 8'h01, 1'b0);
      run_op(1, 8'h05, 8'h07, 1'b1);
      run_op(1, 8'h80, 8'h01, 1'b1);
      run_op(1, 8'h00, 8'h00, 1'b1);
      run_op(4, 8'h3C, 8'h45, 1'b0);
      run_op(4, 8'hFF, 8'h01, 1'b0);
      run_op(4, 8'h05, 8'h07, 1'b1);
      run_op(4, 8'h80, 8'h01, 1'b1);
      for (int i = 0; i < 12; i++) begin
         run_op(1, 8'($urandom), 8'($urandom), 1'($urandom));
         run_op(4, 8'($urandom), 8'($urandom), 1'($urandom));
      end

      // Start held high through the whole operation while operands keep changing.
      cnt_before = done1_cnt;
      @(negedge clk);
      a1 = 8'h10; b1 = 8'h20; mode1 = 1'b0; start1 = 1'b1;
      e = model(8'h10, 8'h20, 1'b0);
      e.cyc = cyc + 1 + 8;
      sb1.push_back(e);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a1 = 8'($urandom); b1 = 8'($urandom); mode1 = 1'($urandom);
      end
      start1 = 1'b0;
      repeat (6) @(negedge clk);
      chk("held_queue_empty", sb1.size(), 0);
      chk("held_done_count", done1_cnt - cnt_before, 1);
      sb1.delete();

      // Reset pulsed in the middle of RUN aborts without a done pulse.
      cnt_before = done1_cnt;
      @(negedge clk);
      a1 = 8'h33; b1 = 8'h44; mode1 = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_busy", busy1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy1, 1'b0);
      chk("abort_result", result1, 8'h00);
      chk("abort_done", done1, 1'b0);
      chk("abort_flags", {cout1, ovf1}, 2'b00);
      repeat (12) @(negedge clk);
      chk("abort_no_done", done1_cnt - cnt_before, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_op(1, 8'hA5, 8'h5A, 1'b1);
      run_op(4, 8'h7F, 8'h80, 1'b1);

      repeat (4) @(negedge clk);
      chk("final_sb1_empty", sb1.size(), 0);
      chk("final_sb4_empty", sb4.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
